sar_ctrl_multi: RTL and testbench
=================================

# sar_ctrl_multi

Parametrised successive-approximation controller for the SAR ADC macro. It drives the capacitive-DAC code, the sample switch, the comparator strobe and the analog input-mux select. It also scans a masked set of channels, supports optional oversampling by power-of-two averaging, and hands each result out through a valid/ready register. It sits between the analog SAR core pins and the digital readout logic in the tile.

## Interface
- RES, 12: conversion resolution in bits (4..16)
- CHANNELS, 4: number of analog mux inputs (1..8)
- SAMPLE_CYCLES, 4: sample-phase length in clocks (>=1)
- MAX_OSR_LOG2, 4: largest oversampling exponent supported
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  begin a conversion sequence (sampled only in IDLE)
- cont_en  in  1  1 = free-running scan, 0 = one result per start
- ch_mask  in  CHANNELS  channels included in the scan
- osr_log2  in  3  averaging exponent; values above MAX_OSR_LOG2 clamp to MAX_OSR_LOG2
- comp_in  in  1  comparator decision; 1 = Vin >= DAC, valid the cycle after comp_latch_o
- sample_o  out  1  sample switch closed
- comp_latch_o  out  1  comparator strobe
- dac_o  out  RES  DAC code
- ch_sel_o  out  clog2(CHANNELS) (min 1)  analog mux select
- result_o  out  RES  averaged conversion result
- result_ch_o  out  clog2(CHANNELS) (min 1)  channel of result_o
- result_valid  out  1  result held
- result_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SAMPLE, SET, DECIDE, DONE.
- IDLE: start=1 and ch_mask!=0 -> SAMPLE. start with ch_mask==0 is ignored.
  - On entry to SAMPLE, latch osr_log2 (clamped) and ch_mask.
  - Channel = lowest set mask bit.
- SAMPLE: sample_o=1 for SAMPLE_CYCLES cycles; dac_o=0; then SET with bit index b=RES-1 and code register=0.
- SET: dac_o = code | (1<<b); comp_latch_o=1 for this one cycle -> DECIDE.
- DECIDE: if comp_in=1, code[b]=1, else code[b]=0; dac_o holds the trial value.
  - If b>0: b-=1 -> SET.
  - Else: acc += code, sample count +=1.
  - If count < 2^osr -> SAMPLE, same channel.
  - Else -> DONE with result_o = acc >> osr (truncating), result_ch_o = channel, result_valid=1.
- Accumulator width is RES+MAX_OSR_LOG2 and cannot overflow. acc and count clear on each new channel.
- DONE: hold result_o, result_ch_o and result_valid until result_valid & result_ready. The controller stalls while waiting; no result is ever dropped.
  - On handshake with cont_en=1: advance to the next set bit of the latched mask above the current channel, wrapping to the lowest set bit. Re-latch ch_mask and osr_log2, then -> SAMPLE.
  - On handshake with cont_en=0 -> IDLE.
- start is ignored outside IDLE.
- Deasserting cont_en mid-sequence lets the current result finish, then -> IDLE.
- ch_sel_o is stable from SAMPLE entry through DONE.
- dac_o=0 in IDLE, SAMPLE and DONE.

## Timing
- Reset values: state IDLE; sample_o, comp_latch_o and dac_o = 0; ch_sel_o = 0; result_o = 0; result_ch_o = 0; result_valid = 0; busy = 0; acc and count = 0.
- A reset asserted in any state returns to IDLE on the next edge. A pending result is discarded.
- The edge that sees start is edge 0. SAMPLE occupies cycles 1..SAMPLE_CYCLES, then 2*RES cycles of SET/DECIDE.
- One raw sample = SAMPLE_CYCLES + 2*RES cycles.
- result_valid rises 2^osr*(SAMPLE_CYCLES+2*RES) cycles after edge 0. Default, osr=0: 28 cycles.
- comp_in is sampled on the edge ending DECIDE. The comparator gets one full cycle after the strobe.
- result_ready is combinational-free: the handshake completes on the edge where both result_valid and result_ready are 1. The next state begins on the following cycle.
- Continuous mode: successive results are SAMPLE_CYCLES+2*RES+1 cycles apart (osr=0) when result_ready is tied high.

## Test plan
- Comparator model: comp_in = registered (vin >= dac_o). vin=0xA5C, ch_mask=0001, start pulse -> result_o=0xA5C and result_ch_o=0, with result_valid at cycle 28. Bench checks the DAC trial sequence 0x800, 0xC00, 0xA00, ...
- vin=0x000 and vin=0xFFF -> results 0x000 and 0xFFF (boundary codes).
- osr_log2=2, vin alternating 0x100/0x103 per sample -> result 0x101 (truncated mean of 0x100, 0x103, 0x100, 0x103) at cycle 112. osr_log2=7 clamps to 4 -> 16 samples.
- cont_en=1, ch_mask=1010, result_ready=1 -> result_ch_o sequence 1, 3, 1, 3 with 29-cycle spacing. ch_mask=0 with start -> busy stays 0.
- result_ready=0 for 50 cycles in DONE -> result_o and result_valid held, sample_o=0, no new conversion. Handshake -> next channel sampled on the following cycle.
- rst asserted at cycle 15 of a conversion -> next cycle all outputs at reset values. A start afterwards converts correctly.

Source files
------------

// File: rtl/sar_ctrl_multi_if.sv
// Result hand-off bus between the SAR controller and the digital readout.
// The controller is the master: it presents a result and its channel,
// and holds them under result_valid until the consumer raises result_ready.
interface sar_ctrl_multi_if #(
  parameter int RES  = 12,
  parameter int CH_W = 2
);
  logic [RES-1:0]  result_o;
  logic [CH_W-1:0] result_ch_o;
  logic            result_valid;
  logic            result_ready;

  modport master (
    output result_o,
    output result_ch_o,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result_o,
    input  result_ch_o,
    input  result_valid,
    output result_ready
  );
endinterface

// File: rtl/sar_ctrl_multi.sv
// Successive-approximation controller for the SAR ADC macro.
// Drives the cap-DAC code, sample switch, comparator strobe and input-mux
// select; scans a masked channel set, averages 2^osr raw samples per
// channel and hands each result out through a valid/ready register.
module sar_ctrl_multi #(
  parameter int RES           = 12,
  parameter int CHANNELS      = 4,
  parameter int SAMPLE_CYCLES = 4,
  parameter int MAX_OSR_LOG2  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cont_en,
  input  logic [CHANNELS-1:0] ch_mask,
  input  logic [2:0]          osr_log2,
  input  logic                comp_in,
  output logic                sample_o,
  output logic                comp_latch_o,
  output logic [RES-1:0]      dac_o,
  output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] ch_sel_o,
  output logic                busy,
  sar_ctrl_multi_if.master    res_if
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BIT_W = $clog2(RES);
  localparam int ACC_W = RES + MAX_OSR_LOG2;
  localparam int CNT_W = MAX_OSR_LOG2 + 1;
  localparam int SC_W  = $clog2(SAMPLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SET,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t              r_state, w_state_next;
  logic [CHANNELS-1:0] r_mask;
  logic [2:0]          r_osr;
  logic [CH_W-1:0]     r_ch;
  logic [SC_W-1:0]     r_samp_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic [RES-1:0]      r_code;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [RES-1:0]      r_result;
  logic [CH_W-1:0]     r_result_ch;
  logic                r_valid;

  logic                w_go;
  logic                w_handshake;
  logic                w_samp_last;
  logic [2:0]          w_osr_clamped;
  logic [RES-1:0]      w_bit_mask;
  logic [RES-1:0]      w_trial;
  logic [RES-1:0]      w_code_next;
  logic [ACC_W-1:0]    w_acc_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_more_samples;

  // Lowest set channel of a mask (0 when the mask is empty).
  function automatic logic [CH_W-1:0] lowest_ch(input logic [CHANNELS-1:0] mask);
    lowest_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_ch = CH_W'(i);
    end
  endfunction

  // Next set channel above cur, wrapping to the lowest set channel.
  function automatic logic [CH_W-1:0] next_ch(input logic [CHANNELS-1:0] mask,
                                               input logic [CH_W-1:0]     cur);
    logic found;
    found   = 1'b0;
    next_ch = lowest_ch(mask);
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && mask[i] && (i > int'(cur))) begin
        next_ch = CH_W'(i);
        found   = 1'b1;
      end
    end
  endfunction

  assign w_go           = start && (ch_mask != '0);
  assign w_handshake    = r_valid && res_if.result_ready;
  assign w_samp_last    = (r_samp_cnt == SC_W'(SAMPLE_CYCLES - 1));
  assign w_osr_clamped  = (osr_log2 > 3'(MAX_OSR_LOG2)) ? 3'(MAX_OSR_LOG2) : osr_log2;
  assign w_bit_mask     = RES'(1) << r_bit;
  assign w_trial        = r_code | w_bit_mask;
  // Bit b of r_code is still clear here, so OR-ing in the decision is enough.
  assign w_code_next    = r_code | (comp_in ? w_bit_mask : '0);
  assign w_acc_next     = r_acc + ACC_W'(w_code_next);
  assign w_cnt_next     = r_cnt + CNT_W'(1);
  assign w_more_samples = (w_cnt_next < (CNT_W'(1) << r_osr));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode and analog-side outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_next = r_state;
    sample_o     = 1'b0;
    comp_latch_o = 1'b0;
    dac_o        = '0;
    busy         = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE:   if (w_go) w_state_next = S_SAMPLE;
      S_SAMPLE: begin
        sample_o = 1'b1;
        if (w_samp_last) w_state_next = S_SET;
      end
      S_SET: begin
        comp_latch_o = 1'b1;
        dac_o        = w_trial;
        w_state_next = S_DECIDE;
      end
      S_DECIDE: begin
        dac_o = w_trial;
        if (r_bit != '0)         w_state_next = S_SET;
        else if (w_more_samples) w_state_next = S_SAMPLE;
        else                     w_state_next = S_DONE;
      end
      S_DONE:   if (w_handshake) w_state_next = cont_en ? S_SAMPLE : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Datapath: channel/oversampling latches, SAR code, accumulator, result register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      r_mask      <= '0;
      r_osr       <= '0;
      r_ch        <= '0;
      r_samp_cnt  <= '0;
      r_bit       <= '0;
      r_code      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_ch <= '0;
      r_valid     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_mask     <= ch_mask;
            r_osr      <= w_osr_clamped;
            r_ch       <= lowest_ch(ch_mask);
            r_acc      <= '0;
            r_cnt      <= '0;
            r_samp_cnt <= '0;
          end
        end
        S_SAMPLE: begin
          r_samp_cnt <= r_samp_cnt + SC_W'(1);
          if (w_samp_last) begin
            r_bit  <= BIT_W'(RES - 1);
            r_code <= '0;
          end
        end
        S_SET: ;
        S_DECIDE: begin
          r_code <= w_code_next;
          if (r_bit != '0) begin
            r_bit <= r_bit - BIT_W'(1);
          end else begin
            r_acc      <= w_acc_next;
            r_cnt      <= w_cnt_next;
            r_samp_cnt <= '0;
            if (!w_more_samples) begin
              r_result    <= RES'(w_acc_next >> r_osr);
              r_result_ch <= r_ch;
              r_valid     <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (w_handshake) begin
            r_valid <= 1'b0;
            if (cont_en) begin
              r_ch       <= next_ch(r_mask, r_ch);
              r_mask     <= ch_mask;
              r_osr      <= w_osr_clamped;
              r_acc      <= '0;
              r_cnt      <= '0;
              r_samp_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ch_sel_o            = r_ch;
  assign res_if.result_o     = r_result;
  assign res_if.result_ch_o  = r_result_ch;
  assign res_if.result_valid = r_valid;

endmodule

// File: tb/tb_sar_ctrl_multi.sv
// Directed bench for sar_ctrl_multi with a registered comparator model.
module tb_sar_ctrl_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cont_en;
  logic [3:0]  ch_mask;
  logic [2:0]  osr_log2;
  logic        comp_in;
  logic        sample_o;
  logic        comp_latch_o;
  logic [11:0] dac_o;
  logic [1:0]  ch_sel_o;
  logic        busy;

  sar_ctrl_multi_if #(.RES(12), .CH_W(2)) res_if ();

  sar_ctrl_multi #(
    .RES(12), .CHANNELS(4), .SAMPLE_CYCLES(4), .MAX_OSR_LOG2(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont_en(cont_en),
    .ch_mask(ch_mask), .osr_log2(osr_log2), .comp_in(comp_in),
    .sample_o(sample_o), .comp_latch_o(comp_latch_o), .dac_o(dac_o),
    .ch_sel_o(ch_sel_o), .busy(busy), .res_if(res_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Analog side: vin alternates between vin_a and vin_b on each new sample phase.
  logic [11:0] vin_a, vin_b, vin_eff;
  int          samp_idx;
  logic        sample_q;
  assign vin_eff = samp_idx[0] ? vin_b : vin_a;

  // Registered comparator (decision visible the cycle after the strobe).
  always @(posedge clk) begin
    if (rst) begin
      comp_in  <= 1'b0;
      sample_q <= 1'b0;
      samp_idx <= 0;
    end else begin
      comp_in  <= (vin_eff >= dac_o);
      sample_q <= sample_o;
      if (sample_o && !sample_q) samp_idx <= samp_idx + 1;
    end
  end

  logic [11:0] trials [0:15];
  int          n_trial;

  // One single-shot conversion; reports result, channel and cycles from edge 0.
  task automatic do_conv(input logic [11:0] va, input logic [11:0] vb,
                         input logic [3:0] mask, input logic [2:0] osr,
                         output logic [11:0] res, output logic [1:0] rch,
                         output int cyc);
    vin_a = va; vin_b = vb;
    ch_mask = mask; osr_log2 = osr; cont_en = 1'b0; result_ready_set(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; n_trial = 0;
    while (!res_if.result_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (comp_latch_o) begin
        if (n_trial < 16) trials[n_trial] = dac_o;
        n_trial++;
      end
    end
    res = res_if.result_o;
    rch = res_if.result_ch_o;
    result_ready_set(1'b1);
    @(negedge clk);
    result_ready_set(1'b0);
  endtask

  task automatic result_ready_set(input logic v);
    res_if.result_ready = v;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cont_en = 1'b0; ch_mask = '0; osr_log2 = '0;
    vin_a = '0; vin_b = '0; result_ready_set(1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sample_o, comp_latch_o, dac_o, ch_sel_o, res_if.result_o,
         res_if.result_ch_o, res_if.result_valid, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got smp=%b latch=%b dac=%h ch=%0d res=%h rch=%0d v=%b busy=%b, want all 0",
               sample_o, comp_latch_o, dac_o, ch_sel_o, res_if.result_o,
               res_if.result_ch_o, res_if.result_valid, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [11:0] r; logic [1:0] c; int cyc;
    do_conv(12'hA5C, 12'hA5C, 4'b0001, 3'd0, r, c, cyc);
    n_cmp++; if (r !== 12'hA5C) begin n_err++; $display("FAIL single_result: got %h want a5c", r); end
    n_cmp++; if (c !== 2'd0) begin n_err++; $display("FAIL single_ch: got %0d want 0", c); end
    n_cmp++; if (cyc !== 28) begin n_err++; $display("FAIL single_latency: got %0d want 28", cyc); end
    n_cmp++; if (n_trial !== 12) begin n_err++; $display("FAIL single_ntrial: got %0d want 12", n_trial); end
    n_cmp++; if (trials[0] !== 12'h800) begin n_err++; $display("FAIL trial0: got %h want 800", trials[0]); end
    n_cmp++; if (trials[1] !== 12'hC00) begin n_err++; $display("FAIL trial1: got %h want c00", trials[1]); end
    n_cmp++; if (trials[2] !== 12'hA00) begin n_err++; $display("FAIL trial2: got %h want a00", trials[2]); end
    n_cmp++; if (trials[3] !== 12'hB00) begin n_err++; $display("FAIL trial3: got %h want b00", trials[3]); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: busy %b want 0", busy); end
  endtask

  task automatic test_boundary;
    logic [11:0] r; logic [1:0] c; int cyc;
    do_conv(12'h000, 12'h000, 4'b0100, 3'd0, r, c, cyc);
    n_cmp++; if (r !== 12'h000 || c !== 2'd2) begin n_err++; $display("FAIL zero_code: got %h ch %0d want 000 ch 2", r, c); end
    n_cmp++; if (cyc !== 28) begin n_err++; $display("FAIL zero_latency: got %0d want 28", cyc); end
    do_conv(12'hFFF, 12'hFFF, 4'b1000, 3'd0, r, c, cyc);
    n_cmp++; if (r !== 12'hFFF || c !== 2'd3) begin n_err++; $display("FAIL full_code: got %h ch %0d want fff ch 3", r, c); end
    n_cmp++; if (cyc !== 28) begin n_err++; $display("FAIL full_latency: got %0d want 28", cyc); end
  endtask

  task automatic test_osr;
    logic [11:0] r; logic [1:0] c; int cyc;
    do_conv(12'h100, 12'h103, 4'b0001, 3'd2, r, c, cyc);
    n_cmp++; if (r !== 12'h101) begin n_err++; $display("FAIL osr2_result: got %h want 101", r); end
    n_cmp++; if (cyc !== 112) begin n_err++; $display("FAIL osr2_latency: got %0d want 112", cyc); end
    do_conv(12'h100, 12'h103, 4'b0010, 3'd7, r, c, cyc);
    n_cmp++; if (r !== 12'h101 || c !== 2'd1) begin n_err++; $display("FAIL osr_clamp_result: got %h ch %0d want 101 ch 1", r, c); end
    n_cmp++; if (cyc !== 448) begin n_err++; $display("FAIL osr_clamp_latency: got %0d want 448", cyc); end
  endtask

  task automatic test_cont;
    int t [0:4]; logic [1:0] ch [0:4]; logic [11:0] rv [0:4];
    int n, cyc, idle_bad;
    logic [1:0] exp_ch [0:4];
    exp_ch[0] = 2'd1; exp_ch[1] = 2'd3; exp_ch[2] = 2'd1; exp_ch[3] = 2'd3; exp_ch[4] = 2'd1;
    vin_a = 12'h3C3; vin_b = 12'h3C3;
    cont_en = 1'b1; ch_mask = 4'b1010; osr_log2 = 3'd0; result_ready_set(1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 125) cont_en = 1'b0;
      if (res_if.result_valid) begin
        t[n] = cyc; ch[n] = res_if.result_ch_o; rv[n] = res_if.result_o; n++;
      end
    end
    n_cmp++; if (n !== 5) begin n_err++; $display("FAIL cont_count: got %0d results want 5", n); end
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (ch[i] !== exp_ch[i] || rv[i] !== 12'h3C3 || t[i] !== 28 + 29 * i) begin
        n_err++;
        $display("FAIL cont_result%0d: got ch %0d val %h at %0d want ch %0d val 3c3 at %0d",
                 i, ch[i], rv[i], t[i], exp_ch[i], 28 + 29 * i);
      end
    end
    @(negedge clk);
    result_ready_set(1'b0);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cont_stop: busy %b want 0", busy); end
    // Empty mask: start must be ignored.
    ch_mask = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_bad = 0;
    repeat (5) begin
      if (busy !== 1'b0 || sample_o !== 1'b0) idle_bad++;
      @(negedge clk);
    end
    n_cmp++; if (idle_bad !== 0) begin n_err++; $display("FAIL empty_mask: %0d busy cycles want 0", idle_bad); end
  endtask

  task automatic test_stall;
    int cyc, held_bad;
    vin_a = 12'h777; vin_b = 12'h777;
    cont_en = 1'b1; ch_mask = 4'b0110; osr_log2 = 3'd0; result_ready_set(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!res_if.result_valid && cyc < 200) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (cyc !== 28 || res_if.result_ch_o !== 2'd1 || res_if.result_o !== 12'h777) begin
      n_err++;
      $display("FAIL stall_first: got %h ch %0d at %0d want 777 ch 1 at 28",
               res_if.result_o, res_if.result_ch_o, cyc);
    end
    held_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (res_if.result_valid !== 1'b1 || res_if.result_o !== 12'h777 ||
          res_if.result_ch_o !== 2'd1 || sample_o !== 1'b0 || dac_o !== 12'h000 ||
          ch_sel_o !== 2'd1 || busy !== 1'b1) held_bad++;
    end
    n_cmp++; if (held_bad !== 0) begin n_err++; $display("FAIL stall_hold: %0d bad cycles want 0", held_bad); end
    result_ready_set(1'b1);
    @(negedge clk);
    result_ready_set(1'b0);
    n_cmp++;
    if (sample_o !== 1'b1 || ch_sel_o !== 2'd2 || res_if.result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_release: got smp=%b ch=%0d v=%b want smp=1 ch=2 v=0",
               sample_o, ch_sel_o, res_if.result_valid);
    end
    cont_en = 1'b0;
    cyc = 0;
    while (!res_if.result_valid && cyc < 200) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (cyc !== 28 || res_if.result_ch_o !== 2'd2 || res_if.result_o !== 12'h777) begin
      n_err++;
      $display("FAIL stall_second: got %h ch %0d at %0d want 777 ch 2 at 28",
               res_if.result_o, res_if.result_ch_o, cyc);
    end
    result_ready_set(1'b1);
    @(negedge clk);
    result_ready_set(1'b0);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_idle: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [11:0] r; logic [1:0] c; int cyc;
    vin_a = 12'h456; vin_b = 12'h456;
    cont_en = 1'b0; ch_mask = 4'b0100; osr_log2 = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || ch_sel_o !== 2'd2) begin
      n_err++; $display("FAIL mid_busy: busy %b ch %0d want 1 ch 2", busy, ch_sel_o);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({sample_o, comp_latch_o, dac_o, ch_sel_o, res_if.result_o,
         res_if.result_ch_o, res_if.result_valid, busy} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got smp=%b latch=%b dac=%h ch=%0d res=%h rch=%0d v=%b busy=%b, want all 0",
               sample_o, comp_latch_o, dac_o, ch_sel_o, res_if.result_o,
               res_if.result_ch_o, res_if.result_valid, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    do_conv(12'h123, 12'h123, 4'b0001, 3'd0, r, c, cyc);
    n_cmp++;
    if (r !== 12'h123 || c !== 2'd0 || cyc !== 28) begin
      n_err++; $display("FAIL post_reset_conv: got %h ch %0d at %0d want 123 ch 0 at 28", r, c, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_osr();
    test_cont();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
